// File: rtl/dmem_sramlike_bridge.sv
// dmem_sramlike_bridge: bridges M-stage load/store requests onto an sram-like data bus.
// Define DMEM_POSTED_WRITE_EN to let stores retire on addr_ok with one write left outstanding.
module dmem_sramlike_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_cancel,
    input  logic              pipe_adv,
    output logic              mem_stall,
    output logic [31:0]       mem_rdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              go;
    logic              blocked;
`ifdef DMEM_POSTED_WRITE_EN
    logic              pend_q, pend_d;
`endif
    assign data_req   = state_q == ADDR;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign mem_rdata  = rdata_q;
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_stall = 1'b0;
        go        = mem_en & ~mem_cancel;
`ifdef DMEM_POSTED_WRITE_EN
        pend_d    = data_data_ok ? 1'b0 : pend_q;
        blocked   = pend_q;
`else
        blocked   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                mem_stall = go;
                if (go && !blocked) begin
                    wr_d    = mem_wr;
                    size_d  = mem_size;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                mem_stall = 1'b1;
                if (data_addr_ok) begin
`ifdef DMEM_POSTED_WRITE_EN
                    state_d = wr_q ? HOLD : DATA;
                    pend_d  = wr_q | pend_d;
`else
                    state_d = DATA;
`endif
                end
            end
            DATA: begin
                mem_stall = 1'b1;
                if (data_data_ok) begin
                    state_d = HOLD;
                    rdata_d = wr_q ? rdata_q : data_rdata;
                end
            end
            HOLD: state_d = pipe_adv ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
`ifdef DMEM_POSTED_WRITE_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_POSTED_WRITE_EN
            pend_q  <= pend_d;
`endif
        end
    end
endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// tb_dmem_sramlike_bridge: table-driven accesses with a load-data scoreboard, plus reset/cancel/posted sequences.
module tb_dmem_sramlike_bridge;
    logic        clk = 1'b0;
    logic        rst, mem_en, mem_wr, mem_cancel, pipe_adv;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall, data_req, data_wr;
    logic [31:0] mem_rdata, data_wdata, data_rdata;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic        data_addr_ok, data_data_ok;

    dmem_sramlike_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cancel(mem_cancel), .pipe_adv(pipe_adv),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          adly;
        int          ddly;
        int          hold;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input vec_t v);
        int          reqs;
        logic [31:0] e;
        bit          posted;
`ifdef DMEM_POSTED_WRITE_EN
        posted = v.wr;
`else
        posted = 1'b0;
`endif
        exp_q.push_back(v.wr ? last_rd : v.rdata);
        if (!v.wr) last_rd = v.rdata;
        mem_en = 1; mem_wr = v.wr; mem_size = v.size; mem_addr = v.addr;
        mem_wdata = v.wdata; mem_cancel = 0; pipe_adv = 0;
        #1;
        chk("idle_stall", {31'd0, mem_stall}, 32'd1);
        chk("idle_req", {31'd0, data_req}, 32'd0);
        step;
        // scramble M-stage inputs and pulse cancel/adv: the issued access must be unaffected
        mem_en = 0; mem_addr = v.addr ^ 32'h0000_0ff0; mem_wdata = ~v.wdata;
        mem_wr = ~v.wr; mem_cancel = 1; pipe_adv = 1;
        reqs = 0;
        for (int k = 0; k <= v.adly; k++) begin
            reqs += int'(data_req);
            chk("addr_stall", {31'd0, mem_stall}, 32'd1);
            chk("data_addr", data_addr, v.addr);
            chk("data_wr", {31'd0, data_wr}, {31'd0, v.wr});
            chk("data_wdata", data_wdata, v.wdata);
            chk("data_size", {30'd0, data_size}, {30'd0, v.size});
            data_addr_ok = (k == v.adly);
            step;
        end
        data_addr_ok = 0;
        chk("req_cycles", reqs, v.adly + 1);
        if (!posted) begin
            for (int k = 0; k <= v.ddly; k++) begin
                chk("data_req_low", {31'd0, data_req}, 32'd0);
                chk("data_stall", {31'd0, mem_stall}, 32'd1);
                data_data_ok = (k == v.ddly);
                data_rdata = (k == v.ddly) ? v.rdata : 32'hbad0_0000 + k;
                step;
            end
            data_data_ok = 0;
        end
        mem_cancel = 0; pipe_adv = 0; mem_wr = 0; mem_addr = 32'h0000_9000;
        e = exp_q.pop_front();
        for (int h = 0; h <= v.hold; h++) begin
            mem_en = (h != v.hold);
            #1;
            chk("hold_stall", {31'd0, mem_stall}, 32'd0);
            chk("hold_req", {31'd0, data_req}, 32'd0);
            chk("mem_rdata", mem_rdata, e);
            pipe_adv = (h == v.hold);
            step;
        end
        pipe_adv = 0; mem_en = 0;
        chk("post_req", {31'd0, data_req}, 32'd0);
        if (posted) begin
            for (int k = 0; k <= v.ddly; k++) begin
                data_data_ok = (k == v.ddly);
                step;
            end
            data_data_ok = 0;
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd2, 32'h0000_1000, 32'h0,          32'hdead_beef, 0, 0, 0};
        vecs[1] = '{1'b0, 2'd2, 32'h0000_1000, 32'h0,          32'h1234_5678, 3, 1, 0};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_1002, 32'h0,          32'habcd_0000, 0, 0, 2};
        vecs[3] = '{1'b1, 2'd0, 32'h0000_1003, 32'h1100_0000, 32'hffff_ffff, 1, 2, 1};
        vecs[4] = '{1'b0, 2'd0, 32'h0000_2001, 32'h0,          32'h0000_5a00, 2, 0, 0};
        vecs[5] = '{1'b1, 2'd2, 32'h0000_3000, 32'hcafe_f00d, 32'h7777_7777, 0, 0, 0};
        last_rd = 32'd0;
        rst = 1; mem_en = 0; mem_wr = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        mem_cancel = 0; pipe_adv = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        step;
        step;
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        mem_en = 1;
        #1;
        chk("rst_stall_req", {31'd0, mem_stall}, 32'd1);
        mem_en = 0; rst = 0;
        step;

        mem_en = 1; mem_cancel = 1; mem_addr = 32'h0000_1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("cancel_stall", {31'd0, mem_stall}, 32'd0);
            chk("cancel_req", {31'd0, data_req}, 32'd0);
            step;
        end
        mem_en = 0; mem_cancel = 0;

        for (int i = 0; i < 6; i++) access(vecs[i]);

        mem_en = 1; mem_wr = 0; mem_size = 2; mem_addr = 32'h0000_4000;
        step;
        mem_en = 0; data_addr_ok = 1;
        step;
        data_addr_ok = 0;
        chk("dr_stall", {31'd0, mem_stall}, 32'd1);
        rst = 1;
        step;
        rst = 0;
        chk("dr_rdata_rst", mem_rdata, 32'd0);
        chk("dr_addr_rst", data_addr, 32'd0);
        data_data_ok = 1; data_rdata = 32'h5;
        step;
        data_data_ok = 0;
        chk("dr_stray_rdata", mem_rdata, 32'd0);
        chk("dr_stray_req", {31'd0, data_req}, 32'd0);
        chk("dr_stray_stall", {31'd0, mem_stall}, 32'd0);
        last_rd = 32'd0;
        access(vecs[0]);

`ifdef DMEM_POSTED_WRITE_EN
        mem_en = 1; mem_wr = 1; mem_size = 2; mem_addr = 32'h0000_2000; mem_wdata = 32'h55aa_55aa;
        #1;
        chk("pw_idle_stall", {31'd0, mem_stall}, 32'd1);
        step;
        mem_en = 0;
        chk("pw_req", {31'd0, data_req}, 32'd1);
        data_addr_ok = 1;
        step;
        data_addr_ok = 0;
        chk("pw_released", {31'd0, mem_stall}, 32'd0);
        pipe_adv = 1;
        step;
        pipe_adv = 0; mem_en = 1; mem_wr = 0; mem_addr = 32'h0000_2004;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pw_block_stall", {31'd0, mem_stall}, 32'd1);
            chk("pw_block_req", {31'd0, data_req}, 32'd0);
            data_data_ok = (k == 2);
            step;
        end
        data_data_ok = 0;
        #1;
        chk("pw_wait_req", {31'd0, data_req}, 32'd0);
        step;
        chk("pw_load_req", {31'd0, data_req}, 32'd1);
        chk("pw_load_addr", data_addr, 32'h0000_2004);
        mem_en = 0; data_addr_ok = 1;
        step;
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h600d_f00d;
        step;
        data_data_ok = 0;
        chk("pw_load_stall", {31'd0, mem_stall}, 32'd0);
        chk("pw_load_rdata", mem_rdata, 32'h600d_f00d);
        pipe_adv = 1;
        step;
        pipe_adv = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
